adder_share_arbiter: RTL and testbench
======================================

ADDER_SHARE_ARBITER -- requirements
Module: adder_share_arbiter

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, operand width.
REQ-002 The module SHALL have parameter CNT_WIDTH, default 4, completed-operation counter width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 req0_valid / req1_valid  input  1  requester n presents an operand pair.
REQ-006 req0_a, req0_b / req1_a, req1_b  input  WIDTH  requester n operands.
REQ-007 req0_ready / req1_ready  output  1  requester n pair accepted this cycle.
REQ-008 res_valid  output  1  result register holds a valid result.
REQ-009 res_sum  output  WIDTH+1  unsigned sum, carry in MSB.
REQ-010 res_id  output  1  index of the requester that produced res_sum.
REQ-011 res_ready  input  1  consumer accepts the result.
REQ-012 op_count  output  CNT_WIDTH  number of completed results, modulo 2^CNT_WIDTH.
REQ-013 op_overflow  output  1  single-cycle pulse when op_count wraps.

Function
REQ-014 The design SHALL share one adder between two requesters, using valid/ready handshakes on both the request side and the result side.
REQ-015 A transfer SHALL occur on a request port when reqN_valid and reqN_ready are both high at a rising edge; a result transfer SHALL occur when res_valid and res_ready are both high.
REQ-016 An output FSM SHALL have states EMPTY (res_valid=0) and FULL (res_valid=1).
  - EMPTY->FULL on grant.
  - FULL->EMPTY on drain with no grant.
  - FULL->FULL on drain with grant, or on no drain.
REQ-017 Grant SHALL be permitted when the state is EMPTY, or when it is FULL and res_ready=1 in the same cycle (full throughput, one result per cycle).
REQ-018 reqN_ready SHALL be combinational: high only for the granted requester, never for both ports in one cycle, and low when grant is not permitted.
REQ-019 Arbitration SHALL be round-robin on a 1-bit last_grant register: when both requesters are valid, grant the requester other than last_grant; when one is valid, grant it; last_grant SHALL update only on a grant.
REQ-020 On grant, res_sum SHALL load a+b of the granted pair, zero-extended to WIDTH+1, and res_id SHALL load the granted index, giving 1-cycle latency from accept to res_valid.
REQ-021 res_sum and res_id SHALL hold stable while FULL and res_ready=0.
REQ-022 op_count SHALL increment by 1 on each result transfer and wrap from 2^CNT_WIDTH-1 to 0.
REQ-023 op_overflow SHALL pulse high for exactly the cycle after the wrapping transfer.
REQ-024 Request-side data SHALL be ignored when reqN_valid=0; the module SHALL NOT require valid to stay asserted.

Reset
REQ-025 While reset=0: res_valid=0, res_sum=0, res_id=0, op_count=0, op_overflow=0, last_grant=1 (requester 0 wins first contention), FSM=EMPTY.
REQ-026 Assertion of reset mid-operation SHALL discard any held result without completing its handshake or counting it.
REQ-027 reqN_ready SHALL be 0 while reset=0.

Structure
REQ-028 A shared package SHALL define the FSM state enum (EMPTY, FULL), the requester-index type, and NUM_REQ=2.
REQ-029 The design SHALL instantiate the existing simple_adder (WIDTH passed through) once, fed by a 2:1 operand mux selected by the grant; no other sub-module.

Verification
REQ-030 Single request: req0 a=8'h12, b=8'h34, res_ready=1 -> req0_ready same cycle; next cycle res_valid=1, res_sum=9'h046, res_id=0; op_count=1.
REQ-031 Contention: both valid every cycle, res_ready=1 -> grants alternate 0,1,0,1 from reset; one result per cycle.
REQ-032 Carry and backpressure: req1 a=8'hFF, b=8'h01 with res_ready=0 for 3 cycles -> res_sum=9'h100 held stable; both reqN_ready=0 until the drain cycle.
REQ-033 Counter wrap: 16 result transfers (CNT_WIDTH=4) -> op_count returns to 0; op_overflow=1 for exactly one cycle after the 16th transfer.
REQ-034 Reset mid-operation: FULL with res_ready=0, then reset asserted -> res_valid=0 and op_count=0 immediately (asynchronous); after release, the first contention grants requester 0.

Source files
------------

// File: rtl/adder_share_arbiter_pkg.sv
// Shared types for the two-requester adder arbiter: output FSM state,
// requester index and requester count.
package adder_share_arbiter_pkg;
    localparam int NUM_REQ = 2;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    typedef logic req_idx_t;
endpackage

// File: rtl/adder_share_arbiter_adder.sv
// Plain combinational unsigned adder; carry lands in the extra MSB.
module simple_adder #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH:0]   sum
);
    assign sum = {1'b0, a} + {1'b0, b};
endmodule

// File: rtl/adder_share_arbiter.sv
// One adder shared by two valid/ready requesters, round-robin arbitrated,
// feeding a single-entry result register that drains at full throughput.
module adder_share_arbiter
    import adder_share_arbiter_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int CNT_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req0_valid,
    input  logic [WIDTH-1:0]     req0_a,
    input  logic [WIDTH-1:0]     req0_b,
    output logic                 req0_ready,
    input  logic                 req1_valid,
    input  logic [WIDTH-1:0]     req1_a,
    input  logic [WIDTH-1:0]     req1_b,
    output logic                 req1_ready,
    output logic                 res_valid,
    output logic [WIDTH:0]       res_sum,
    output logic                 res_id,
    input  logic                 res_ready,
    output logic [CNT_WIDTH-1:0] op_count,
    output logic                 op_overflow
);
    state_e               state_q, state_d;
    req_idx_t             last_grant_q, last_grant_d;
    logic [WIDTH:0]       res_sum_q, res_sum_d;
    req_idx_t             res_id_q, res_id_d;
    logic [CNT_WIDTH-1:0] op_count_q, op_count_d;
    logic                 op_overflow_q, op_overflow_d;

    logic                 grant_ok;
    logic                 grant;
    logic                 drain;
    req_idx_t             sel;
    logic [WIDTH-1:0]     mux_a, mux_b;
    logic [WIDTH:0]       add_sum;

    // Contention goes to whoever did not win last; a lone requester always wins.
    always_comb begin
        sel = 1'b0;
        if (req0_valid && req1_valid) sel = ~last_grant_q;
        else if (req1_valid)          sel = 1'b1;
    end

    // Ready is gated by reset so nothing is accepted while the block is held.
    assign grant_ok   = reset && ((state_q == EMPTY) || res_ready);
    assign grant      = grant_ok && (req0_valid || req1_valid);
    assign drain      = (state_q == FULL) && res_ready;
    assign req0_ready = grant && (sel == 1'b0);
    assign req1_ready = grant && (sel == 1'b1);

    assign mux_a = sel ? req1_a : req0_a;
    assign mux_b = sel ? req1_b : req0_b;

    simple_adder #(
        .WIDTH (WIDTH)
    ) u_adder (
        .a   (mux_a),
        .b   (mux_b),
        .sum (add_sum)
    );

    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        res_sum_d     = res_sum_q;
        res_id_d      = res_id_q;
        op_count_d    = op_count_q;
        op_overflow_d = 1'b0;

        if (grant) begin
            state_d      = FULL;
            last_grant_d = sel;
            res_sum_d    = add_sum;
            res_id_d     = sel;
        end else if (drain) begin
            state_d = EMPTY;
        end

        if (drain) begin
            op_count_d    = op_count_q + 1'b1;
            op_overflow_d = &op_count_q;
        end
    end

    // last_grant resets to 1 so requester 0 wins the first contention.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= EMPTY;
            last_grant_q  <= 1'b1;
            res_sum_q     <= '0;
            res_id_q      <= 1'b0;
            op_count_q    <= '0;
            op_overflow_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            res_sum_q     <= res_sum_d;
            res_id_q      <= res_id_d;
            op_count_q    <= op_count_d;
            op_overflow_q <= op_overflow_d;
        end
    end

    assign res_valid   = (state_q == FULL);
    assign res_sum     = res_sum_q;
    assign res_id      = res_id_q;
    assign op_count    = op_count_q;
    assign op_overflow = op_overflow_q;
endmodule

// File: tb/tb_adder_share_arbiter.sv
// Directed bench for adder_share_arbiter: handshake, arbitration, carry,
// backpressure, counter wrap and asynchronous reset.
module tb_adder_share_arbiter;
    localparam int WIDTH     = 8;
    localparam int CNT_WIDTH = 4;

    logic                 clk;
    logic                 reset;
    logic                 req0_valid, req1_valid;
    logic [WIDTH-1:0]     req0_a, req0_b, req1_a, req1_b;
    logic                 req0_ready, req1_ready;
    logic                 res_valid;
    logic [WIDTH:0]       res_sum;
    logic                 res_id;
    logic                 res_ready;
    logic [CNT_WIDTH-1:0] op_count;
    logic                 op_overflow;

    int checks   = 0;
    int failures = 0;

    adder_share_arbiter #(
        .WIDTH     (WIDTH),
        .CNT_WIDTH (CNT_WIDTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req0_valid  (req0_valid),
        .req0_a      (req0_a),
        .req0_b      (req0_b),
        .req0_ready  (req0_ready),
        .req1_valid  (req1_valid),
        .req1_a      (req1_a),
        .req1_b      (req1_b),
        .req1_ready  (req1_ready),
        .res_valid   (res_valid),
        .res_sum     (res_sum),
        .res_id      (res_id),
        .res_ready   (res_ready),
        .op_count    (op_count),
        .op_overflow (op_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge, leaving 1 time unit of margin.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        #2;
        reset = 1'b1;
        #1;
    endtask

    initial begin
        reset      = 1'b0;
        req0_valid = 1'b1; req0_a = 8'h11; req0_b = 8'h22;
        req1_valid = 1'b1; req1_a = 8'h33; req1_b = 8'h44;
        res_ready  = 1'b1;
        #3;
        chk("rst_req0_ready", 32'(req0_ready), 32'd0);
        chk("rst_req1_ready", 32'(req1_ready), 32'd0);
        chk("rst_res_valid",  32'(res_valid),  32'd0);
        chk("rst_res_sum",    32'(res_sum),    32'd0);
        chk("rst_res_id",     32'(res_id),     32'd0);
        chk("rst_op_count",   32'(op_count),   32'd0);
        chk("rst_overflow",   32'(op_overflow), 32'd0);
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        reset = 1'b1;
        #1;

        // Single request from port 0
        req0_valid = 1'b1; req0_a = 8'h12; req0_b = 8'h34;
        #1;
        chk("single_req0_ready", 32'(req0_ready), 32'd1);
        chk("single_req1_ready", 32'(req1_ready), 32'd0);
        tick();
        req0_valid = 1'b0;
        chk("single_res_valid", 32'(res_valid), 32'd1);
        chk("single_res_sum",   32'(res_sum),   32'h046);
        chk("single_res_id",    32'(res_id),    32'd0);
        tick();
        chk("single_op_count",  32'(op_count),  32'd1);
        chk("single_drained",   32'(res_valid), 32'd0);

        // Contention from reset: grants alternate 0,1,0,1
        pulse_reset();
        req0_valid = 1'b1; req0_a = 8'd1;  req0_b = 8'd2;
        req1_valid = 1'b1; req1_a = 8'd10; req1_b = 8'd20;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("cont_req0_ready_%0d", i), 32'(req0_ready), 32'(i % 2 == 0));
            chk($sformatf("cont_req1_ready_%0d", i), 32'(req1_ready), 32'(i % 2 == 1));
            tick();
            chk($sformatf("cont_res_valid_%0d", i), 32'(res_valid), 32'd1);
            chk($sformatf("cont_res_id_%0d", i),    32'(res_id),    32'(i % 2));
            chk($sformatf("cont_res_sum_%0d", i),   32'(res_sum),   (i % 2 == 0) ? 32'd3 : 32'd30);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();
        chk("cont_op_count", 32'(op_count),  32'd4);
        chk("cont_empty",    32'(res_valid), 32'd0);

        // Carry with backpressure; last grant was 1, so next contention goes to 0
        res_ready  = 1'b0;
        req1_valid = 1'b1; req1_a = 8'hFF; req1_b = 8'h01;
        #1;
        chk("carry_req1_ready", 32'(req1_ready), 32'd1);
        tick();
        req0_valid = 1'b1; req0_a = 8'h05; req0_b = 8'h05;
        req1_a = 8'h07; req1_b = 8'h07;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("bp_res_sum_%0d", i),    32'(res_sum),    32'h100);
            chk($sformatf("bp_res_id_%0d", i),     32'(res_id),     32'd1);
            chk($sformatf("bp_req0_ready_%0d", i), 32'(req0_ready), 32'd0);
            chk($sformatf("bp_req1_ready_%0d", i), 32'(req1_ready), 32'd0);
            tick();
        end
        res_ready = 1'b1;
        #1;
        chk("drain_req0_ready", 32'(req0_ready), 32'd1);
        chk("drain_req1_ready", 32'(req1_ready), 32'd0);
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        chk("drain_res_sum",  32'(res_sum),  32'h00A);
        chk("drain_res_id",   32'(res_id),   32'd0);
        chk("drain_op_count", 32'(op_count), 32'd5);
        tick();
        chk("drain2_op_count", 32'(op_count), 32'd6);

        // Counter wrap after 16 transfers from reset
        pulse_reset();
        req0_valid = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            req0_a = 8'(k - 1); req0_b = 8'(k - 1);
            tick();
            chk($sformatf("wrap_sum_%0d", k),   32'(res_sum),     32'(2 * (k - 1)));
            chk($sformatf("wrap_count_%0d", k), 32'(op_count),    32'(k - 1));
            chk($sformatf("wrap_ovf_%0d", k),   32'(op_overflow), 32'd0);
        end
        req0_valid = 1'b0;
        tick();
        chk("wrap_count_zero", 32'(op_count),    32'd0);
        chk("wrap_ovf_pulse",  32'(op_overflow), 32'd1);
        tick();
        chk("wrap_ovf_clear",  32'(op_overflow), 32'd0);
        chk("wrap_count_hold", 32'(op_count),    32'd0);

        // Reset mid-operation while a result is held
        req0_valid = 1'b1; req0_a = 8'd3; req0_b = 8'd4;
        tick();
        tick();
        req0_valid = 1'b0;
        res_ready  = 1'b0;
        tick();
        chk("mid_held_valid", 32'(res_valid), 32'd1);
        chk("mid_held_count", 32'(op_count),  32'd1);
        chk("mid_held_sum",   32'(res_sum),   32'd7);
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        reset = 1'b0;
        #1;
        chk("mid_rst_valid",      32'(res_valid),  32'd0);
        chk("mid_rst_count",      32'(op_count),   32'd0);
        chk("mid_rst_sum",        32'(res_sum),    32'd0);
        chk("mid_rst_req0_ready", 32'(req0_ready), 32'd0);
        chk("mid_rst_req1_ready", 32'(req1_ready), 32'd0);
        reset = 1'b1;
        res_ready = 1'b1;
        #1;
        chk("post_rst_req0_ready", 32'(req0_ready), 32'd1);
        chk("post_rst_req1_ready", 32'(req1_ready), 32'd0);
        tick();
        chk("post_rst_res_id",  32'(res_id),  32'd0);
        chk("post_rst_res_sum", 32'(res_sum), 32'd7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
